alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `alu` instance (5-bit op, WIDTH-bit X/Y/Z) among NREQ requesters. Each requester presents op/X/Y with a valid/ready handshake. The arbiter latches the winning request and drives the shared ALU inputs for ALU_LAT cycles. It then captures the result and returns it with the requester id over a backpressured response channel. It sits between instruction-issue/test-sequencer logic and the shared ALU datapath.

---
 rtl/alu_arbiter_if.sv | 24 ++
 rtl/alu_arbiter.sv | 79 +++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and response handshake bundle between requesters and the arbiter
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*5-1:0] req_op;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [WIDTH-1:0] resp_z;
  modport master (
    output req_valid, req_op, req_x, req_y, resp_ready,
    input req_ready, resp_valid, resp_id, resp_z
  );
  modport slave (
    input req_valid, req_op, req_x, req_y, resp_ready,
    output req_ready, resp_valid, resp_id, resp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NREQ requesters
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int ALU_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  alu_arbiter_if.slave bus,
  output logic [4:0] alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_z,
  output logic [15:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, id, win, idx;
  logic [3:0] cnt;
  logic accept;
  // search from the port after the last winner; the smallest offset is written last and wins
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[idx]) win = idx;
    end
  end
  assign accept = reset_n && state == IDLE && |bus.req_valid;
  assign bus.req_ready = accept ? NREQ'(1) << win : '0;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // next state: accept, wait out the ALU latency, then hold the response until taken
  always_comb begin
    nxt = state;
    nxt = accept ? EXEC
        : state == EXEC && cnt == 4'd0 ? DONE
        : state == DONE && bus.resp_ready ? IDLE
        : state;
  end
  // operand latch, result capture and completion counting
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr <= IDW'(NREQ - 1);
      id <= '0;
      cnt <= '0;
      alu_op <= '0;
      alu_x <= '0;
      alu_y <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id <= '0;
      bus.resp_z <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        alu_op <= bus.req_op[5*win +: 5];
        alu_x <= bus.req_x[WIDTH*win +: WIDTH];
        alu_y <= bus.req_y[WIDTH*win +: WIDTH];
        id <= win;
        ptr <= win;
        cnt <= 4'(ALU_LAT - 1);
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          bus.resp_z <= alu_z;
          bus.resp_id <= id;
          bus.resp_valid <= 1'b1;
        end else cnt <= cnt - 4'd1;
      end
      if (state == DONE && bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
        ops_done <= ops_done + 16'(ops_done != 16'hFFFF);
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (ALU_LAT 1 and 3) checked against a transaction-level model
module tb_alu_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [N-1:0] v [2];
  logic [N*5-1:0] op [2];
  logic [N*W-1:0] x [2];
  logic [N*W-1:0] y [2];
  logic rr [2];
  logic [N-1:0] rdy [2];
  logic rv [2];
  logic [IW-1:0] rid [2];
  logic [W-1:0] rz [2];
  logic [4:0] aop [2];
  logic [W-1:0] ax [2];
  logic [W-1:0] ay [2];
  logic [15:0] od [2];
  int errs = 0;
  int checks = 0;

  function automatic logic [W-1:0] alu_f(logic [4:0] o, logic [W-1:0] a, logic [W-1:0] b);
    return o == 5'h01 ? a + b : o == 5'h02 ? a ^ b : o == 5'h03 ? a - b : o == 5'h04 ? a & b : '0;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g ? 3 : 1;
    alu_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();
    logic [4:0] a_op;
    logic [W-1:0] a_x, a_y, a_z;
    logic [15:0] done;
    assign bus.req_valid = v[g];
    assign bus.req_op = op[g];
    assign bus.req_x = x[g];
    assign bus.req_y = y[g];
    assign bus.resp_ready = rr[g];
    assign rdy[g] = bus.req_ready;
    assign rv[g] = bus.resp_valid;
    assign rid[g] = bus.resp_id;
    assign rz[g] = bus.resp_z;
    assign aop[g] = a_op;
    assign ax[g] = a_x;
    assign ay[g] = a_y;
    assign od[g] = done;
    assign a_z = alu_f(a_op, a_x, a_y);
    alu_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW), .ALU_LAT(LAT)) u (
      .clk(clk), .reset_n(rst_n), .bus(bus), .alu_op(a_op), .alu_x(a_x),
      .alu_y(a_y), .alu_z(a_z), .ops_done(done)
    );
    int m_ptr, m_left;
    bit m_busy, m_rv;
    logic [IW-1:0] m_rid, p_id;
    logic [W-1:0] m_rz, m_x, m_y, p_z;
    logic [4:0] m_op;
    logic [15:0] m_cnt;
    always @(negedge clk) begin
      int w;
      logic [N-1:0] e_rdy;
      if (!rst_n) begin
        m_ptr = N - 1; m_left = 0; m_busy = 0; m_rv = 0; m_rid = '0; m_rz = '0;
        m_x = '0; m_y = '0; m_op = '0; m_cnt = '0;
      end
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && v[g][(m_ptr + k) % N]) w = (m_ptr + k) % N;
      e_rdy = (rst_n && !m_busy && w >= 0) ? N'(1) << w : '0;
      chk($sformatf("L%0d req_ready", g), 32'(rdy[g]), 32'(e_rdy));
      chk($sformatf("L%0d ready onehot", g), 32'($onehot0(rdy[g])), 32'd1);
      chk($sformatf("L%0d resp_valid", g), 32'(rv[g]), 32'(m_rv));
      chk($sformatf("L%0d resp_id", g), 32'(rid[g]), 32'(m_rid));
      chk($sformatf("L%0d resp_z", g), 32'(rz[g]), 32'(m_rz));
      chk($sformatf("L%0d alu_op", g), 32'(aop[g]), 32'(m_op));
      chk($sformatf("L%0d alu_x", g), 32'(ax[g]), 32'(m_x));
      chk($sformatf("L%0d alu_y", g), 32'(ay[g]), 32'(m_y));
      chk($sformatf("L%0d ops_done", g), 32'(od[g]), 32'(m_cnt));
      if (rst_n) begin
        if (m_rv && rr[g]) begin
          m_rv = 0; m_busy = 0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_busy && !m_rv) begin
          if (m_left == 1) begin m_rv = 1; m_rid = p_id; m_rz = p_z; end
          else m_left--;
        end else if (!m_busy && w >= 0) begin
          m_busy = 1; m_left = LAT; m_ptr = w;
          m_op = op[g][5*w +: 5]; m_x = x[g][W*w +: W]; m_y = y[g][W*w +: W];
          p_id = IW'(w); p_z = alu_f(m_op, m_x, m_y);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(int g, int i, bit vv, logic [4:0] o, logic [W-1:0] a, logic [W-1:0] b);
    v[g][i] = vv;
    op[g][5*i +: 5] = o;
    x[g][W*i +: W] = a;
    y[g][W*i +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_od(int g, logic [15:0] e, string nm);
    @(negedge clk);
    chk(nm, 32'(od[g]), 32'(e));
    step();
  endtask

  task automatic one(int g, int i, logic [4:0] o, logic [W-1:0] a, logic [W-1:0] b,
                     logic [W-1:0] ez, int elat, int hold, string nm);
    int n;
    setreq(g, i, 1'b1, o, a, b);
    rr[g] = 1'b0;
    @(negedge clk);
    chk({nm, " ready"}, 32'(rdy[g]), 32'(1) << i);
    step();
    v[g][i] = 1'b0;
    for (n = 1; n < 20; n++) begin
      @(negedge clk);
      if (rv[g]) break;
      chk({nm, " hold x"}, 32'(ax[g]), 32'(a));
      chk({nm, " hold y"}, 32'(ay[g]), 32'(b));
      step();
    end
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " z"}, 32'(rz[g]), 32'(ez));
    chk({nm, " id"}, 32'(rid[g]), 32'(i));
    for (int h = 0; h < hold; h++) begin
      step();
      @(negedge clk);
      chk({nm, " stall valid"}, 32'(rv[g]), 32'd1);
      chk({nm, " stall z"}, 32'(rz[g]), 32'(ez));
      chk({nm, " stall id"}, 32'(rid[g]), 32'(i));
      chk({nm, " stall ready"}, 32'(rdy[g]), 32'd0);
    end
    step();
    rr[g] = 1'b1;
    @(negedge clk);
    step();
    rr[g] = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] ids [6];
    logic [IW-1:0] exp_ids [6];
    logic [N-1:0] acc [2];
    int k;
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      v[g] = '0; op[g] = '0; x[g] = '0; y[g] = '0; rr[g] = 1'b0;
    end
    step();
    do_reset();
    one(0, 0, 5'h01, 16'h0003, 16'h0004, 16'h0007, 2, 0, "t1");
    chk_od(0, 16'd1, "t1 ops_done");
    one(0, 2, 5'h02, 16'hFFFF, 16'h00FF, 16'hFF00, 2, 5, "t3");
    chk_od(0, 16'd2, "t3 ops_done");
    one(1, 3, 5'h01, 16'hFFFF, 16'h0001, 16'h0000, 4, 0, "t4");
    chk_od(1, 16'd1, "t4 ops_done");
    do_reset();
    for (int i = 0; i < N; i++) setreq(0, i, 1'b1, 5'(1 + $urandom_range(3)), 16'($urandom), 16'($urandom));
    rr[0] = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      @(negedge clk);
      acc[0] = v[0] & rdy[0];
      if (rv[0] && rr[0]) begin ids[k] = rid[0]; k++; end
      step();
      for (int i = 0; i < N; i++)
        if (acc[0][i]) setreq(0, i, 1'b1, 5'(1 + $urandom_range(3)), 16'($urandom), 16'($urandom));
    end
    chk("t2 responses", 32'(k), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2 grant %0d", i), 32'(ids[i]), 32'(exp_ids[i]));
    v[0] = '0;
    repeat (6) step();
    setreq(1, 1, 1'b1, 5'h01, 16'h0005, 16'h0006);
    @(negedge clk);
    chk("t5 accept", 32'(rdy[1]), 32'b0010);
    step();
    v[1] = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5 resp_valid", 32'(rv[1]), 32'd0);
    chk("t5 alu_op", 32'(aop[1]), 32'd0);
    chk("t5 alu_x", 32'(ax[1]), 32'd0);
    chk("t5 alu_y", 32'(ay[1]), 32'd0);
    chk("t5 ops_done", 32'(od[1]), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) setreq(1, i, 1'b1, 5'h02, 16'($urandom), 16'($urandom));
    @(negedge clk);
    chk("t5 ptr reset", 32'(rdy[1]), 32'b0001);
    step();
    v[1] = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) acc[g] = v[g] & rdy[g];
      step();
      rst_n = c != 700;
      for (int g = 0; g < 2; g++) begin
        rr[g] = $urandom_range(3) != 0;
        for (int i = 0; i < N; i++)
          if (acc[g][i] || !v[g][i])
            setreq(g, i, $urandom_range(2) != 0, 5'(1 + $urandom_range(3)), 16'($urandom), 16'($urandom));
      end
    end
    for (int g = 0; g < 2; g++) begin v[g] = '0; rr[g] = 1'b1; end
    repeat (8) step();
    rr[0] = 1'b0;
    force lane[0].u.ops_done = 16'hFFFD;
    lane[0].m_cnt = 16'hFFFD;
    #2;
    release lane[0].u.ops_done;
    chk_od(0, 16'hFFFD, "t6 preload");
    one(0, 1, 5'h01, 16'h0001, 16'h0001, 16'h0002, 2, 0, "t6a");
    chk_od(0, 16'hFFFE, "t6 count a");
    one(0, 1, 5'h02, 16'h00F0, 16'h0F00, 16'h0FF0, 2, 0, "t6b");
    chk_od(0, 16'hFFFF, "t6 count b");
    one(0, 1, 5'h01, 16'h8000, 16'h8000, 16'h0000, 2, 0, "t6c");
    chk_od(0, 16'hFFFF, "t6 saturate");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
